pbit_sweep_ctrl: RTL and testbench
==================================

Name: pbit_sweep_ctrl

Overview:
Sequences Gibbs-style sweeps of a p-bit state vector through the enc energy-evaluation datapath. The controller owns the p-bit state register and visits bits 0..PBITS-1 in order. For each bit it drives the state and a one-hot index into enc, waits for the datapath to settle, compares the returned weighted sum against LFSR noise, and writes the new bit value. It sits between the host/start logic and one enc instance, and repeats for a programmed number of sweeps.

Parameters:
PBITS, 16, number of p-bits; width of state and index vectors.
ENC_LAT, 1, settle cycles allowed for enc output after enc_state/enc_index change (>=1).
LFSR_SEED, 32'hACE1_2024, nonzero reset/start seed of internal 32-bit Galois LFSR (taps 32,22,2,1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a run; sampled only in IDLE
abort  in  1  terminates a run; takes effect on the next clock edge
init_state  in  PBITS  state vector loaded on accepted start
num_sweeps  in  16  sweeps to perform; captured on accepted start
noise_shift  in  5  arithmetic right-shift applied to LFSR value (temperature control); captured on start
enc_state  out  PBITS  state vector presented to enc
enc_index  out  PBITS  one-hot bit under update presented to enc
enc_out  in  32 signed  enc weighted-sum result
state  out  PBITS  current p-bit state (same register as enc_state)
busy  out  1  high from accepted start until DONE/abort
done  out  1  one-cycle pulse at normal completion
sweep_cnt  out  16  completed sweeps in the current/last run

Behaviour:
- Reset: state=0, enc_index=0, busy=0, done=0, sweep_cnt=0, LFSR=LFSR_SEED, FSM=IDLE. Reset mid-run discards all progress.
- FSM states: IDLE, SETTLE, UPDATE, DONE.
- IDLE: start=1 -> load state<=init_state, capture num_sweeps/noise_shift, sweep_cnt<=0, bit ptr<=0, LFSR<=LFSR_SEED, busy<=1.
  - num_sweeps==0 -> DONE.
  - otherwise -> SETTLE with enc_index=1<<0 and settle counter=0.
- SETTLE: enc_state/enc_index held stable. Counter increments each cycle. After ENC_LAT cycles in SETTLE -> UPDATE.
- UPDATE (one cycle):
  - noise = $signed(lfsr) >>> noise_shift.
  - new bit = (enc_out > noise) signed 32-bit compare; written to state[ptr] at end of cycle.
  - LFSR advances exactly once per UPDATE.
  - ptr<PBITS-1 -> ptr+1, enc_index shifts left, -> SETTLE.
  - ptr==PBITS-1 -> sweep_cnt+1.
    - If new count==num_sweeps -> DONE.
    - Else ptr<=0, enc_index=1, -> SETTLE.
- Per-bit cost ENC_LAT+1 cycles. One sweep = PBITS*(ENC_LAT+1) cycles.
- DONE: done=1 for exactly one cycle, busy<=0, enc_index<=0, -> IDLE. state and sweep_cnt hold until next accepted start.
- enc_index is zero in IDLE/DONE and exactly one-hot in SETTLE/UPDATE.
- abort=1 in any non-IDLE state:
  - next state IDLE, busy=0, no done pulse, enc_index=0.
  - state keeps bits written so far; a bit whose UPDATE coincides with abort IS written.
- start while busy is ignored. start and abort together in IDLE: abort wins (start ignored).
- noise_shift=31 makes noise ∈ {0,-1}: enc_out>=1 always gives 1, enc_out<=-1 always gives 0.
- sweep_cnt saturates only via num_sweeps bound; no wrap possible (16-bit compare).

Test Plan:
- Reset then idle: after rst, state=0, busy=0, done=0, enc_index=0; start held low for 10 cycles -> no change.
- Deterministic sweep: PBITS=4, ENC_LAT=1, noise_shift=31, init_state=4'b0000, num_sweeps=1, bench model returns enc_out=+5 when enc_index selects an even bit, -5 otherwise.
  - Expect state=4'b0101.
  - Expect done pulse 1+4*2 cycles after start (start accepted on cycle 0, done high on cycle 9).
  - Expect sweep_cnt=1.
- Zero sweeps: num_sweeps=0, init_state=4'b1010 -> done on second cycle after start, state=4'b1010, no enc_index activity.
- Multi-sweep with ENC_LAT=3: num_sweeps=3, PBITS=4.
  - Expect enc_index sequence 1,2,4,8 repeated 3 times, each held 4 cycles.
  - Expect sweep_cnt=3 and busy high for exactly 48 cycles.
- Abort mid-sweep: assert abort during UPDATE of bit 1 (enc_out=+5, noise_shift=31) -> state[1]=1, later bits unchanged, busy=0 next cycle, done never asserted. A subsequent start runs normally.
- Reset mid-run and start-while-busy: pulse start during SETTLE -> no restart (enc_index sequence unaffected). Assert rst mid-sweep -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/pbit_sweep_ctrl.sv
// Gibbs-sweep sequencer: owns the p-bit state vector, walks bits 0..PBITS-1 through
// the enc datapath and sets each bit by comparing the weighted sum against LFSR noise.
module pbit_sweep_ctrl #(
  parameter int          PBITS     = 16,
  parameter int          ENC_LAT   = 1,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [PBITS-1:0]    init_state,
  input  logic [15:0]         num_sweeps,
  input  logic [4:0]          noise_shift,
  output logic [PBITS-1:0]    enc_state,
  output logic [PBITS-1:0]    enc_index,
  input  logic signed [31:0]  enc_out,
  output logic [PBITS-1:0]    state,
  output logic                busy,
  output logic                done,
  output logic [15:0]         sweep_cnt
);

  localparam int PTR_W = (PBITS > 1) ? $clog2(PBITS) : 1;
  localparam int CNT_W = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(PBITS - 1);
  localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(ENC_LAT - 1);
  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    UPDATE,
    DONE
  } fsm_t;

  fsm_t fsm, fsm_next;

  logic [PBITS-1:0] state_q;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] settle_cnt;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic [15:0]      num_sweeps_q;
  logic [4:0]       noise_shift_q;
  logic [15:0]      sweep_cnt_q;
  logic [15:0]      sweep_inc;
  logic signed [31:0] noise;
  logic             new_bit;
  logic             last_bit;
  logic             sweeps_done;
  logic             accept;
  logic             active;
  logic [PBITS-1:0] idx_onehot;

  assign accept      = (fsm == IDLE) && start && !abort;
  assign active      = (fsm == SETTLE) || (fsm == UPDATE);
  assign idx_onehot  = PBITS'(1) << ptr;
  assign lfsr_next   = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
  assign noise       = $signed(lfsr) >>> noise_shift_q;
  assign new_bit     = enc_out > noise;
  assign last_bit    = (ptr == LAST_PTR);
  assign sweep_inc   = sweep_cnt_q + 16'd1;
  assign sweeps_done = (sweep_inc == num_sweeps_q);

  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  // Abort overrides every transition out of a running state
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE: begin
        if (accept) fsm_next = (num_sweeps == 16'd0) ? DONE : SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == LAST_SETTLE) fsm_next = UPDATE;
      end
      UPDATE: begin
        if (last_bit && sweeps_done) fsm_next = DONE;
        else                         fsm_next = SETTLE;
      end
      DONE:    fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
    if (abort && (fsm != IDLE)) fsm_next = IDLE;
  end

  // The bit under update is written even when abort lands on the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= '0;
      ptr           <= '0;
      settle_cnt    <= '0;
      lfsr          <= LFSR_SEED;
      num_sweeps_q  <= '0;
      noise_shift_q <= '0;
      sweep_cnt_q   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            state_q       <= init_state;
            num_sweeps_q  <= num_sweeps;
            noise_shift_q <= noise_shift;
            sweep_cnt_q   <= '0;
            ptr           <= '0;
            settle_cnt    <= '0;
            lfsr          <= LFSR_SEED;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + CNT_W'(1);
        end
        UPDATE: begin
          state_q    <= (state_q & ~idx_onehot) | (new_bit ? idx_onehot : '0);
          lfsr       <= lfsr_next;
          settle_cnt <= '0;
          if (last_bit) begin
            sweep_cnt_q <= sweep_inc;
            ptr         <= '0;
          end else begin
            ptr <= ptr + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign enc_state = state_q;
  assign state     = state_q;
  assign enc_index = active ? idx_onehot : '0;
  assign busy      = active;
  assign done      = (fsm == DONE);
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_pbit_sweep_ctrl.sv
// Directed bench for pbit_sweep_ctrl: two 4-bit instances (ENC_LAT=1 and ENC_LAT=3)
// driven by shared stimulus, each fed by its own small enc response model.
module tb_pbit_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  init_state = '0;
  logic [15:0] num_sweeps = '0;
  logic [4:0]  noise_shift = '0;
  int          enc_mode = 0;

  logic [3:0]  enc_state_a, enc_index_a, state_a;
  logic        busy_a, done_a;
  logic [15:0] sweep_cnt_a;
  logic signed [31:0] enc_out_a;

  logic [3:0]  enc_state_b, enc_index_b, state_b;
  logic        busy_b, done_b;
  logic [15:0] sweep_cnt_b;
  logic signed [31:0] enc_out_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pbit_sweep_ctrl #(.PBITS(4), .ENC_LAT(1), .LFSR_SEED(32'hACE1_2024)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .init_state(init_state), .num_sweeps(num_sweeps), .noise_shift(noise_shift),
    .enc_state(enc_state_a), .enc_index(enc_index_a), .enc_out(enc_out_a),
    .state(state_a), .busy(busy_a), .done(done_a), .sweep_cnt(sweep_cnt_a)
  );

  pbit_sweep_ctrl #(.PBITS(4), .ENC_LAT(3), .LFSR_SEED(32'hACE1_2024)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .init_state(init_state), .num_sweeps(num_sweeps), .noise_shift(noise_shift),
    .enc_state(enc_state_b), .enc_index(enc_index_b), .enc_out(enc_out_b),
    .state(state_b), .busy(busy_b), .done(done_b), .sweep_cnt(sweep_cnt_b)
  );

  // Mode 0: +5 on even bits, -5 on odd; mode 1: always 0; otherwise always +5
  function automatic logic signed [31:0] enc_model(input logic [3:0] idx, input int mode);
    if (mode == 0)      return ((idx & 4'b0101) != 4'b0000) ? 32'sd5 : -32'sd5;
    else if (mode == 1) return 32'sd0;
    else                return 32'sd5;
  endfunction

  always_comb enc_out_a = enc_model(enc_index_a, enc_mode);
  always_comb enc_out_b = enc_model(enc_index_b, enc_mode);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Leaves the bench observing cycle 1 (first cycle after the accepting edge)
  task automatic applyStimulus(input logic [3:0] init, input logic [15:0] ns, input logic [4:0] sh);
    init_state = init; num_sweeps = ns; noise_shift = sh;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic runToDone(input int first_cycle, output int cycles);
    cycles = first_cycle;
    while (!done_a && cycles < 200) begin
      step();
      cycles++;
    end
    checkOutput("done_reached", {31'd0, done_a}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int busy_cycles;
    int k;
    int done_seen;
    logic [31:0] lf;
    logic [3:0]  exp_state;
    logic [31:0] exp_idx;

    // Reset and idle
    step(); step();
    rst = 1'b0;
    checkOutput("rst_state", 32'(state_a), 32'h0);
    checkOutput("rst_busy", 32'(busy_a), 32'h0);
    checkOutput("rst_done", 32'(done_a), 32'h0);
    checkOutput("rst_index", 32'(enc_index_a), 32'h0);
    checkOutput("rst_sweep", 32'(sweep_cnt_a), 32'h0);
    for (int i = 0; i < 10; i++) step();
    checkOutput("idle_busy", 32'(busy_a), 32'h0);
    checkOutput("idle_state", 32'(state_a), 32'h0);
    checkOutput("idle_index", 32'(enc_index_a), 32'h0);

    // Deterministic single sweep
    $display("[TB] deterministic sweep");
    pulseReset(); enc_mode = 0;
    applyStimulus(4'b0000, 16'd1, 5'd31);
    checkOutput("det_first_index", 32'(enc_index_a), 32'h1);
    runToDone(1, cyc);
    checkOutput("det_done_cycle", 32'(cyc), 32'd9);
    checkOutput("det_state", 32'(state_a), 32'h5);
    checkOutput("det_sweep", 32'(sweep_cnt_a), 32'd1);
    checkOutput("det_busy_in_done", 32'(busy_a), 32'h0);
    checkOutput("det_index_in_done", 32'(enc_index_a), 32'h0);
    step();
    checkOutput("det_done_pulse", 32'(done_a), 32'h0);
    checkOutput("det_state_hold", 32'(state_a), 32'h5);
    checkOutput("det_sweep_hold", 32'(sweep_cnt_a), 32'd1);

    // Zero sweeps
    $display("[TB] zero sweeps");
    pulseReset();
    applyStimulus(4'b1010, 16'd0, 5'd31);
    checkOutput("zero_done", 32'(done_a), 32'h1);
    checkOutput("zero_index", 32'(enc_index_a), 32'h0);
    checkOutput("zero_state", 32'(state_a), 32'hA);
    step();
    checkOutput("zero_done_clear", 32'(done_a), 32'h0);
    checkOutput("zero_index_idle", 32'(enc_index_a), 32'h0);

    // Multi-sweep on the ENC_LAT=3 instance
    $display("[TB] multi-sweep ENC_LAT=3");
    pulseReset(); enc_mode = 0;
    applyStimulus(4'b0000, 16'd3, 5'd31);
    busy_cycles = 0;
    k = 0;
    while (!done_b && k < 200) begin
      if (busy_b) busy_cycles++;
      if (k < 48) begin
        exp_idx = 32'd1 << ((k / 4) % 4);
        checkOutput("multi_index", 32'(enc_index_b), exp_idx);
      end
      k++;
      step();
    end
    checkOutput("multi_done", 32'(done_b), 32'h1);
    checkOutput("multi_busy_cycles", 32'(busy_cycles), 32'd48);
    checkOutput("multi_sweep", 32'(sweep_cnt_b), 32'd3);
    checkOutput("multi_state", 32'(state_b), 32'h5);

    // Abort during UPDATE of bit 1
    $display("[TB] abort mid-sweep");
    pulseReset(); enc_mode = 2;
    applyStimulus(4'b0000, 16'd1, 5'd31);
    step(); step(); step();
    checkOutput("abort_pre_index", 32'(enc_index_a), 32'h2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_state", 32'(state_a), 32'h3);
    checkOutput("abort_busy", 32'(busy_a), 32'h0);
    checkOutput("abort_index", 32'(enc_index_a), 32'h0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_a) done_seen++;
      step();
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);
    checkOutput("abort_state_hold", 32'(state_a), 32'h3);
    enc_mode = 0;
    applyStimulus(4'b0000, 16'd1, 5'd31);
    runToDone(1, cyc);
    checkOutput("post_abort_cycle", 32'(cyc), 32'd9);
    checkOutput("post_abort_state", 32'(state_a), 32'h5);

    // Start and abort together in IDLE
    $display("[TB] start with abort");
    pulseReset();
    init_state = 4'b1111; num_sweeps = 16'd1; noise_shift = 5'd31;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checkOutput("sa_busy", 32'(busy_a), 32'h0);
    checkOutput("sa_index", 32'(enc_index_a), 32'h0);
    checkOutput("sa_state", 32'(state_a), 32'h0);

    // Start while busy is ignored
    $display("[TB] start while busy");
    pulseReset(); enc_mode = 0;
    applyStimulus(4'b0000, 16'd1, 5'd31);
    step(); step();
    checkOutput("swb_index_c3", 32'(enc_index_a), 32'h2);
    init_state = 4'b1111; num_sweeps = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("swb_index_c4", 32'(enc_index_a), 32'h2);
    step();
    checkOutput("swb_index_c5", 32'(enc_index_a), 32'h4);
    runToDone(5, cyc);
    checkOutput("swb_done_cycle", 32'(cyc), 32'd9);
    checkOutput("swb_state", 32'(state_a), 32'h5);
    checkOutput("swb_sweep", 32'(sweep_cnt_a), 32'd1);

    // Reset mid-run
    $display("[TB] reset mid-run");
    step();
    num_sweeps = 16'd1;
    applyStimulus(4'b0000, 16'd1, 5'd31);
    step(); step(); step(); step();
    checkOutput("mrst_pre_state", 32'(state_a), 32'h1);
    checkOutput("mrst_pre_busy", 32'(busy_a), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mrst_state", 32'(state_a), 32'h0);
    checkOutput("mrst_index", 32'(enc_index_a), 32'h0);
    checkOutput("mrst_busy", 32'(busy_a), 32'h0);
    checkOutput("mrst_done", 32'(done_a), 32'h0);
    checkOutput("mrst_sweep", 32'(sweep_cnt_a), 32'h0);

    // enc_out = 0 against 1-bit noise: each bit follows the sign of the LFSR
    $display("[TB] LFSR-driven noise");
    pulseReset(); enc_mode = 1;
    lf = 32'hACE1_2024;
    for (int i = 0; i < 4; i++) begin
      exp_state[i] = lf[31];
      lf = (lf >> 1) ^ (lf[0] ? 32'h8020_0003 : 32'd0);
    end
    applyStimulus(4'b0110, 16'd1, 5'd31);
    runToDone(1, cyc);
    checkOutput("lfsr_state", 32'(state_a), 32'(exp_state));
    checkOutput("lfsr_done_cycle", 32'(cyc), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
